serial_audio_rx: RTL and testbench
==================================

SERIAL_AUDIO_RX -- requirements
Module: serial_audio_rx

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 24, meaning bits captured per channel slot, legal range 16..24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per serial input, legal range 2..3.
REQ-003 SHALL have port capture_clk, input, 1, the single clock; BCK SHALL be at most capture_clk/4.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx_en, input, 1, receive enable, level-sensitive.
REQ-006 SHALL have port rx_bck, input, 1, external bit clock, asynchronous to capture_clk.
REQ-007 SHALL have port rx_lrck, input, 1, word select: 0 = left, 1 = right.
REQ-008 SHALL have port rx_data_pin, input, 1, serial data, MSB first.
REQ-009 SHALL have port rx_word, output, 32, captured word.
REQ-010 SHALL have port rx_wren, output, 1, one-cycle write strobe to the downstream async_fifo_32 write side.
REQ-011 SHALL have port rx_full, input, 1, FIFO full flag.
REQ-012 SHALL have port rx_overflow, output, 1, sticky flag: a word was dropped.
REQ-013 SHALL have port rx_frame_err, output, 1, sticky flag: a short slot was seen (present only under the Configuration macro).

Function
REQ-014 SHALL pass rx_bck, rx_lrck and rx_data_pin each through SYNC_STAGES flops, then one edge-detect flop; a BCK rise is synced_bck high while its delayed copy is low.
REQ-015 SHALL sample synced lrck and data only on a detected BCK rise; lrck_prev SHALL update on each such rise.
REQ-016 SHALL implement the states IDLE, SKIP, SHIFT and HOLD.
REQ-017 IDLE: on a BCK rise where lrck differs from lrck_prev (a slot boundary), SHALL latch chan equal to the new lrck and go to SKIP. The BCK rise that detects the boundary is the I2S one-bit delay.
REQ-018 SKIP: on the next BCK rise, SHALL shift in data as the MSB, set bit count to 1, and go to SHIFT.
REQ-019 SHIFT: on each BCK rise, SHALL shift data in and increment the count. When the count reaches SAMPLE_BITS, SHALL go to HOLD and request an emit.
REQ-020 HOLD: SHALL ignore data bits; on a slot boundary SHALL latch the new chan and go to SKIP.
REQ-021 A slot boundary in SKIP or SHIFT SHALL discard the partial word, latch the new chan and go to SKIP. No word SHALL be emitted for the short slot.
REQ-022 The emit SHALL occur exactly one capture_clk after the final bit's BCK-rise cycle.
REQ-023 The emitted word SHALL be rx_word = {chan, 7'b0, sample}, where sample is left-aligned to bit 23 and its LSBs are zero-filled when SAMPLE_BITS < 24.
REQ-024 If rx_full is low at emit, rx_wren SHALL be high for exactly one cycle with rx_word valid in that same cycle.
REQ-025 If rx_full is high at emit, rx_wren SHALL stay low, the word SHALL be dropped and rx_overflow SHALL be set. There SHALL be no retry.
REQ-026 rx_word SHALL hold its value between strobes.
REQ-027 rx_en low SHALL force IDLE within one cycle and suppress any pending emit. Synchronizers and sticky flags SHALL keep running or holding.

Reset
REQ-028 When rst is high at a capture_clk edge, state SHALL go to IDLE, and count, shift register, chan, lrck_prev and all synchronizer flops SHALL clear to 0.
REQ-029 Reset values SHALL be rx_word = 0, rx_wren = 0, rx_overflow = 0, rx_frame_err = 0.
REQ-030 rst asserted mid-slot SHALL abort the slot with no emit; after release the block SHALL wait in IDLE for the next boundary.

Configuration
REQ-031 Macro SERIAL_AUDIO_RX_FRAME_CHECK_EN defined: the REQ-021 condition SHALL set rx_frame_err, held until rst.
REQ-032 Macro undefined: the rx_frame_err port and its logic SHALL be absent; short slots SHALL be discarded silently.

Structure
REQ-033 A shared package serial_audio_pkg SHALL hold the rx state enum, WORD_W = 32, CHAN_BIT = 31 and SAMPLE_MSB = 23.
REQ-034 One sub-module, serial_audio_sync, SHALL implement the synchronizer plus BCK rise detector, instantiated once for the three inputs.

Verification
REQ-035 With BCK = capture_clk/8, 32-bit slots, left = 0xABCDEF and right = 0x123456, the bench SHALL see rx_wren pulses carrying 0x00ABCDEF then 0x80123456.
REQ-036 With rx_full held high for one right slot, that word SHALL be absent, rx_overflow SHALL read 1, and the next left word SHALL be written normally.
REQ-037 With LRCK toggling after 10 bits, there SHALL be no emit for that slot, rx_frame_err SHALL read 1 (macro defined) and the following full slot SHALL be captured correctly.
REQ-038 With rst pulsed at bit 12 of a slot, there SHALL be no emit, all outputs SHALL read 0, and the first word after release SHALL come from a complete slot.
REQ-039 With SAMPLE_BITS = 16 and left = 0xBEEF, the word SHALL be 0x00BEEF00.
REQ-040 With rx_en dropped mid-slot and raised two slots later, there SHALL be no emits while low and correct words after the next boundary.

Source files
------------

// File: rtl/serial_audio_pkg.sv
// -----------------------------------------------------------------------------
// serial_audio_pkg
// Shared definitions for the serial audio receive path: the receive state
// enum and the layout of the 32-bit word handed to the downstream FIFO
// (bit 31 = channel, bits 30:24 = zero, bits 23:0 = left-aligned sample).
// -----------------------------------------------------------------------------
package serial_audio_pkg;

    localparam int WORD_W     = 32;
    localparam int CHAN_BIT   = 31;
    localparam int SAMPLE_MSB = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/serial_audio_sync.sv
// -----------------------------------------------------------------------------
// serial_audio_sync
// Brings the three asynchronous serial-audio pins (BCK, LRCK, DATA) into the
// capture clock domain through SYNC_STAGES flops each, and flags BCK rising
// edges with one extra delay flop on the synchronized BCK. LRCK and DATA go
// through the same depth, so they stay aligned with the detected BCK rise.
//
// Ports
//   clk         capture clock
//   rst         synchronous active-high reset, clears every flop
//   async_bck   raw bit clock pin
//   async_lrck  raw word-select pin
//   async_data  raw serial data pin
//   sync_lrck   synchronized word select
//   sync_data   synchronized serial data
//   bck_rise    one-cycle pulse: synchronized BCK high, delayed copy low
// -----------------------------------------------------------------------------
module serial_audio_sync
    import serial_audio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_bck,
    input  logic async_lrck,
    input  logic async_data,
    output logic sync_lrck,
    output logic sync_data,
    output logic bck_rise
);

    // Lane order inside each stage: {data, lrck, bck}
    logic [2:0] chain [SYNC_STAGES];
    logic       bck_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= 3'b000;
            end
            bck_dly <= 1'b0;
        end else begin
            chain[0] <= {async_data, async_lrck, async_bck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            bck_dly <= chain[SYNC_STAGES-1][0];
        end
    end

    assign sync_lrck = chain[SYNC_STAGES-1][1];
    assign sync_data = chain[SYNC_STAGES-1][2];
    assign bck_rise  = chain[SYNC_STAGES-1][0] & ~bck_dly;

endmodule

// File: rtl/serial_audio_rx.sv
// -----------------------------------------------------------------------------
// serial_audio_rx
// I2S-style serial audio receiver. Oversamples BCK/LRCK/DATA with
// capture_clk (BCK at most capture_clk/4), detects slot boundaries as LRCK
// changes seen on BCK rises, skips the one-bit I2S delay, shifts in
// SAMPLE_BITS bits MSB first and writes {chan, 7'b0, sample} into a FIFO.
//
// Optional feature: define SERIAL_AUDIO_RX_FRAME_CHECK_EN to add the sticky
// rx_frame_err output, set whenever a slot ends before SAMPLE_BITS bits were
// captured. Without the macro such slots are discarded silently.
//
// Ports
//   capture_clk   single clock
//   rst           synchronous active-high reset
//   rx_en         receive enable (level); low forces IDLE, no emits
//   rx_bck        external bit clock (asynchronous)
//   rx_lrck       word select, 0 = left, 1 = right
//   rx_data_pin   serial data, MSB first
//   rx_word       captured word, held between strobes
//   rx_wren       one-cycle FIFO write strobe
//   rx_full       FIFO full flag
//   rx_overflow   sticky: a word was dropped because the FIFO was full
//   rx_frame_err  sticky: a short slot was seen (macro builds only)
// -----------------------------------------------------------------------------
module serial_audio_rx
    import serial_audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              capture_clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              rx_bck,
    input  logic              rx_lrck,
    input  logic              rx_data_pin,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_wren,
    input  logic              rx_full,
    output logic              rx_overflow
`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
    ,
    output logic              rx_frame_err
`endif
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

    logic                   sync_lrck;
    logic                   sync_data;
    logic                   bck_rise;
    logic                   boundary;

    rx_state_t              state;
    rx_state_t              state_next;
    logic [CNT_W-1:0]       count;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [SAMPLE_BITS-1:0] shreg_next;
    logic                   chan;
    logic                   lrck_prev;

    logic                   latch_chan;
    logic                   shift_first;
    logic                   shift_more;
    logic                   emit;

    // Place the captured sample at bits 23:0 of the word, left-aligned so
    // narrower sample widths are zero-filled at the bottom.
    function automatic logic [WORD_W-1:0] pack_word(input logic ch,
                                                    input logic [SAMPLE_BITS-1:0] smp);
        logic [WORD_W-1:0]   w;
        logic [SAMPLE_MSB:0] ext;
        ext = '0;
        ext[SAMPLE_BITS-1:0] = smp;
        ext = ext << (SAMPLE_MSB + 1 - SAMPLE_BITS);
        w = '0;
        w[CHAN_BIT] = ch;
        w[SAMPLE_MSB:0] = ext;
        return w;
    endfunction

    serial_audio_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (capture_clk),
        .rst        (rst),
        .async_bck  (rx_bck),
        .async_lrck (rx_lrck),
        .async_data (rx_data_pin),
        .sync_lrck  (sync_lrck),
        .sync_data  (sync_data),
        .bck_rise   (bck_rise)
    );

    assign boundary   = (sync_lrck != lrck_prev);
    assign shreg_next = {shreg[SAMPLE_BITS-2:0], sync_data};

    // State register
    always_ff @(posedge capture_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-rise actions. The rise that reveals the LRCK change
    // carries the previous slot's last bit, so a new slot always starts in
    // SKIP and takes its MSB on the following rise.
    always_comb begin
        state_next  = state;
        latch_chan  = 1'b0;
        shift_first = 1'b0;
        shift_more  = 1'b0;
        emit        = 1'b0;
        if (!rx_en) begin
            state_next = IDLE;
        end else if (bck_rise) begin
            if (boundary) begin
                latch_chan = 1'b1;
                state_next = SKIP;
            end else begin
                case (state)
                    SKIP: begin
                        shift_first = 1'b1;
                        state_next  = SHIFT;
                    end
                    SHIFT: begin
                        shift_more = 1'b1;
                        if (count == CNT_W'(SAMPLE_BITS - 1)) begin
                            emit       = 1'b1;
                            state_next = HOLD;
                        end
                    end
                    default: state_next = state;
                endcase
            end
        end
    end

    // Capture datapath
    always_ff @(posedge capture_clk) begin
        if (rst) begin
            count     <= '0;
            shreg     <= '0;
            chan      <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            if (bck_rise) begin
                lrck_prev <= sync_lrck;
            end
            if (latch_chan) begin
                chan <= sync_lrck;
            end
            if (shift_first) begin
                shreg <= {{(SAMPLE_BITS-1){1'b0}}, sync_data};
                count <= CNT_W'(1);
            end else if (shift_more) begin
                shreg <= shreg_next;
                count <= count + 1'b1;
            end
        end
    end

    // Output stage: the word is registered on the final bit's rise cycle, so
    // the strobe lands exactly one capture_clk later.
    always_ff @(posedge capture_clk) begin
        if (rst) begin
            rx_word     <= '0;
            rx_wren     <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_wren <= 1'b0;
            if (emit) begin
                if (rx_full) begin
                    rx_overflow <= 1'b1;
                end else begin
                    rx_wren <= 1'b1;
                    rx_word <= pack_word(chan, shreg_next);
                end
            end
        end
    end

`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
    // A boundary arriving while a word is still being collected is a short slot.
    logic short_slot;
    assign short_slot = rx_en && bck_rise && boundary &&
                        ((state == SKIP) || (state == SHIFT));

    always_ff @(posedge capture_clk) begin
        if (rst) begin
            rx_frame_err <= 1'b0;
        end else if (short_slot) begin
            rx_frame_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_audio_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_audio_rx
// Drives an I2S-style stream (BCK = capture_clk/8) into two receivers, one
// with 24-bit and one with 16-bit samples, and compares their FIFO writes and
// sticky flags against a slot-level reference model. The stream is described
// as a list of LRCK phases: chan, length in BCKs, and the payload sent MSB
// first after the one-bit delay slot.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_audio_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rx_en;
    logic        rx_bck;
    logic        rx_lrck;
    logic        rx_data_pin;
    logic        rx_full;
    logic [31:0] word_a, word_b;
    logic        wren_a, wren_b;
    logic        ovf_a, ovf_b;
`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
    logic        ferr_a, ferr_b;
`endif

    serial_audio_rx #(.SAMPLE_BITS(24), .SYNC_STAGES(2)) dut_a (
        .capture_clk (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .rx_bck      (rx_bck),
        .rx_lrck     (rx_lrck),
        .rx_data_pin (rx_data_pin),
        .rx_word     (word_a),
        .rx_wren     (wren_a),
        .rx_full     (rx_full),
        .rx_overflow (ovf_a)
`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
        ,
        .rx_frame_err(ferr_a)
`endif
    );

    serial_audio_rx #(.SAMPLE_BITS(16), .SYNC_STAGES(3)) dut_b (
        .capture_clk (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .rx_bck      (rx_bck),
        .rx_lrck     (rx_lrck),
        .rx_data_pin (rx_data_pin),
        .rx_word     (word_b),
        .rx_wren     (wren_b),
        .rx_full     (rx_full),
        .rx_overflow (ovf_b)
`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
        ,
        .rx_frame_err(ferr_b)
`endif
    );

    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference model state, index 0 = 24-bit receiver, 1 = 16-bit receiver
    int          sb [2] = '{24, 16};
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    logic        oexp [2] = '{1'b0, 1'b0};
    logic        fexp [2] = '{1'b0, 1'b0};
    logic        pend [2] = '{1'b0, 1'b0};
    logic        prev_chan = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected FIFO word: channel on top, first sb payload bits left-aligned
    function automatic logic [31:0] exp_word(input logic ch, input logic [30:0] pay, input int bits);
        logic [23:0] top;
        top = pay[30:7];
        top = top & ~((24'h1 << (24 - bits)) - 24'h1);
        return {ch, 7'b0, top};
    endfunction

    // Write-strobe monitor
    logic        wren_a_d = 1'b0;
    logic        wren_b_d = 1'b0;
    logic [31:0] e_a, e_b;
    always @(negedge clk) begin
        if (wren_a) begin
            chk("a_wren_width", {31'b0, wren_a_d}, 32'd0);
            if (q_a.size() == 0) begin
                chk("a_unexpected_wren", {31'b0, wren_a}, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_word", word_a, e_a);
                last_a = e_a;
            end
        end
        if (wren_b) begin
            chk("b_wren_width", {31'b0, wren_b_d}, 32'd0);
            if (q_b.size() == 0) begin
                chk("b_unexpected_wren", {31'b0, wren_b}, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_word", word_b, e_b);
                last_b = e_b;
            end
        end
        wren_a_d = wren_a;
        wren_b_d = wren_b;
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a_word"}, word_a, 32'd0);
        chk({tag, "_a_wren"}, {31'b0, wren_a}, 32'd0);
        chk({tag, "_a_ovf"},  {31'b0, ovf_a},  32'd0);
        chk({tag, "_b_word"}, word_b, 32'd0);
        chk({tag, "_b_wren"}, {31'b0, wren_b}, 32'd0);
        chk({tag, "_b_ovf"},  {31'b0, ovf_b},  32'd0);
`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
        chk({tag, "_a_ferr"}, {31'b0, ferr_a}, 32'd0);
        chk({tag, "_b_ferr"}, {31'b0, ferr_b}, 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("rst");
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            oexp[d] = 1'b0;
            fexp[d] = 1'b0;
            pend[d] = 1'b0;
        end
        last_a    = '0;
        last_b    = '0;
        prev_chan = 1'b0;
    endtask

    task automatic drive_bit(input logic lr, input logic d);
        @(negedge clk);
        rx_bck      = 1'b0;
        rx_lrck     = lr;
        rx_data_pin = d;
        repeat (4) @(negedge clk);
        rx_bck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One LRCK phase of len BCKs; drop_at / rst_at (>= 0) drop rx_en or pulse
    // rst before that bit index.
    task automatic run_phase(input logic ch, input int len, input logic [30:0] pay,
                             input logic full, input int drop_at, input int rst_at);
        logic bnd;
        logic live;
        bnd  = (ch != prev_chan);
        live = rx_en && bnd && (drop_at < 0) && (rst_at < 0);
        rx_full = full;
        for (int d = 0; d < 2; d++) begin
            if (pend[d] && rx_en && bnd) fexp[d] = 1'b1;
            pend[d] = 1'b0;
            if (live) begin
                if (len >= sb[d] + 1) begin
                    if (full) oexp[d] = 1'b1;
                    else if (d == 0) q_a.push_back(exp_word(ch, pay, sb[d]));
                    else q_b.push_back(exp_word(ch, pay, sb[d]));
                end else begin
                    pend[d] = 1'b1;
                end
            end
        end
        for (int i = 0; i < len; i++) begin
            if (i == drop_at) rx_en = 1'b0;
            if (i == rst_at) do_reset();
            drive_bit(ch, (i == 0) ? 1'($urandom_range(0, 1)) : pay[31-i]);
        end
        prev_chan = ch;
        repeat (2) @(negedge clk);
        chk("a_pending", 32'(q_a.size()), 32'd0);
        chk("b_pending", 32'(q_b.size()), 32'd0);
        chk("a_word_hold", word_a, last_a);
        chk("b_word_hold", word_b, last_b);
        chk("a_overflow", {31'b0, ovf_a}, {31'b0, oexp[0]});
        chk("b_overflow", {31'b0, ovf_b}, {31'b0, oexp[1]});
`ifdef SERIAL_AUDIO_RX_FRAME_CHECK_EN
        chk("a_frame_err", {31'b0, ferr_a}, {31'b0, fexp[0]});
        chk("b_frame_err", {31'b0, ferr_b}, {31'b0, fexp[1]});
`endif
    endtask

    function automatic logic [30:0] rnd();
        return 31'($urandom);
    endfunction

    initial begin
        logic ch;
        int   len;
        int   r;
        rst         = 1'b1;
        rx_en       = 1'b1;
        rx_bck      = 1'b0;
        rx_lrck     = 1'b0;
        rx_data_pin = 1'b0;
        rx_full     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("init");
        rst = 1'b0;

        // Left first with no preceding boundary: nothing captured
        run_phase(1'b0, 32, rnd(), 1'b0, -1, -1);
        run_phase(1'b1, 32, rnd(), 1'b0, -1, -1);
        // Known words: 0x00ABCDEF then 0x80123456
        run_phase(1'b0, 32, {24'hABCDEF, 7'h55}, 1'b0, -1, -1);
        run_phase(1'b1, 32, {24'h123456, 7'h2A}, 1'b0, -1, -1);
        // 16-bit receiver sees 0x00BEEF00
        run_phase(1'b0, 32, {16'hBEEF, 15'h1357}, 1'b0, -1, -1);
        // FIFO full for a right slot, then a normal left
        run_phase(1'b1, 32, rnd(), 1'b1, -1, -1);
        run_phase(1'b0, 32, rnd(), 1'b0, -1, -1);
        // Short slot: LRCK toggles after 10 data bits
        run_phase(1'b1, 11, rnd(), 1'b0, -1, -1);
        run_phase(1'b0, 32, rnd(), 1'b0, -1, -1);
        run_phase(1'b1, 32, rnd(), 1'b0, -1, -1);
        // Reset at data bit 12 of a left slot
        run_phase(1'b0, 32, rnd(), 1'b0, -1, 13);
        run_phase(1'b1, 32, rnd(), 1'b0, -1, -1);
        run_phase(1'b0, 32, rnd(), 1'b0, -1, -1);
        // rx_en dropped mid-slot, raised two slots later
        run_phase(1'b1, 32, rnd(), 1'b0, 6, -1);
        run_phase(1'b0, 32, rnd(), 1'b0, -1, -1);
        run_phase(1'b1, 32, rnd(), 1'b0, -1, -1);
        rx_en = 1'b1;
        run_phase(1'b0, 32, rnd(), 1'b0, -1, -1);
        run_phase(1'b1, 32, rnd(), 1'b0, -1, -1);

        // Randomized slots: mostly full length, some short for one or both widths
        ch = 1'b1;
        for (int p = 0; p < 24; p++) begin
            ch = ~ch;
            r  = int'($urandom_range(0, 9));
            if (r < 7)      len = int'($urandom_range(26, 32));
            else if (r < 9) len = 20;
            else            len = 8;
            run_phase(ch, len, rnd(), ($urandom_range(0, 3) == 0), -1, -1);
        end
        ch = ~ch;
        run_phase(ch, 32, rnd(), 1'b0, -1, -1);
        ch = ~ch;
        run_phase(ch, 32, rnd(), 1'b0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
